// File: rtl/avalon_mm_master_pkg.sv
// rtl/avalon_mm_master_pkg.sv - shared types and defaults for the Avalon-MM host controller
// Contents:
//   state_t      controller FSM states
//   DEF_*        default parameter values
//   bus_req_t    one captured bus request (address, write data, direction)
package avalon_mm_master_pkg;

   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 1024;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      RD     = 3'd2,
      RDWAIT = 3'd3,
      RESP   = 3'd4
   } state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic                  write;
   } bus_req_t;

endpackage

// File: rtl/avalon_mm_master_ctrl_if.sv
// rtl/avalon_mm_master_ctrl_if.sv - command/response and Avalon-MM signal bundle
// Groups:
//   cmd_*   local command port (valid/ready), into the controller
//   rsp_*   local response port (valid/ready), out of the controller
//   avm_*   Avalon-MM host-side bus signals
// Modports:
//   master  the controller's view
//   slave   the environment's view (command source, response sink, responder)
interface avalon_mm_master_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0]   avm_address;
   logic                avm_read;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_waitrequest;
   logic                avm_readdatavalid;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             avm_readdata, avm_waitrequest, avm_readdatavalid,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             avm_readdata, avm_waitrequest, avm_readdatavalid,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
   );

endinterface

// File: rtl/avalon_mm_master_ctrl_mm_timeout_counter.sv
// rtl/avalon_mm_master_ctrl_mm_timeout_counter.sv - bus-transfer watchdog counter
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         restart counting from zero (wins over enable)
//   enable        count one cycle
//   expired       count has reached TIMEOUT_CYC-1
// The count saturates at TIMEOUT_CYC-1 so expired stays high until cleared.
module mm_timeout_counter #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/avalon_mm_master_ctrl.sv
// rtl/avalon_mm_master_ctrl.sv - Avalon-MM host issuing single read/write transfers
// Turns one command from the cmd_* port into one Avalon-MM transfer and returns
// one response on rsp_*. One transfer outstanding; avm_* and rsp_* registered.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      avalon_mm_master_ctrl_if.master (cmd_*, rsp_*, avm_*)
// Build option:
//   MM_MASTER_TIMEOUT_EN  adds a watchdog; a transfer not finished within
//                         TIMEOUT_CYC cycles is abandoned with rsp_err=1.
module avalon_mm_master_ctrl
   import avalon_mm_master_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input logic                    clk,
   input logic                    reset_n,
   avalon_mm_master_ctrl_if.master bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              timeout_hit;

`ifdef MM_MASTER_TIMEOUT_EN
   logic accept;
   logic busy;

   // Entering WR/RD always comes from an accepted command, so the accept
   // strobe is the counter's clear.
   assign accept = (state_q == IDLE) && bus.cmd_valid;
   assign busy   = (state_q == WR) || (state_q == RD) || (state_q == RDWAIT);

   mm_timeout_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (accept),
      .enable  (busy),
      .expired (timeout_hit)
   );
`else
   // No watchdog: the controller waits on the responder indefinitely.
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         read_q      <= read_d;
         write_q     <= write_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      read_d      = read_q;
      write_d     = write_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               addr_d  = bus.cmd_addr;
               wdata_d = bus.cmd_wdata;
               if (bus.cmd_write) begin
                  write_d = 1'b1;
                  state_d = WR;
               end else begin
                  read_d  = 1'b1;
                  state_d = RD;
               end
            end
         end

         WR: begin
            if (!bus.avm_waitrequest || timeout_hit) begin
               write_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = '0;
               err_d       = bus.avm_waitrequest;
               state_d     = RESP;
            end
         end

         RD: begin
            // A completed handshake with data in the same cycle beats the
            // watchdog; otherwise the watchdog is checked before falling into
            // RDWAIT so an expired count is never carried over.
            if (!bus.avm_waitrequest && bus.avm_readdatavalid) begin
               read_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = bus.avm_readdata;
               err_d       = 1'b0;
               state_d     = RESP;
            end else if (timeout_hit) begin
               read_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = '0;
               err_d       = 1'b1;
               state_d     = RESP;
            end else if (!bus.avm_waitrequest) begin
               read_d  = 1'b0;
               state_d = RDWAIT;
            end
         end

         RDWAIT: begin
            if (bus.avm_readdatavalid) begin
               rsp_valid_d = 1'b1;
               rdata_d     = bus.avm_readdata;
               err_d       = 1'b0;
               state_d     = RESP;
            end else if (timeout_hit) begin
               rsp_valid_d = 1'b1;
               rdata_d     = '0;
               err_d       = 1'b1;
               state_d     = RESP;
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            read_d      = 1'b0;
            write_d     = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   assign bus.cmd_ready      = (state_q == IDLE);
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_rdata      = rdata_q;
`ifdef MM_MASTER_TIMEOUT_EN
   assign bus.rsp_err        = err_q;
`else
   assign bus.rsp_err        = 1'b0;
   logic unused_err;
   assign unused_err = err_q;
`endif
   assign bus.avm_address    = addr_q;
   assign bus.avm_read       = read_q;
   assign bus.avm_write      = write_q;
   assign bus.avm_writedata  = wdata_q;
   assign bus.avm_byteenable = '1;

endmodule
